key_i2c_cmd: RTL and testbench

- Consumes the single-cycle press pulses from two debounced key channels (write key, read key) and converts each press into one I2C transaction request for the downstream I2C master.
- Issues start/rw/address/write-data to the master and waits for completion with a timeout.
- Holds the last byte read for display and keeps a sticky error flag.
- Sits between the key debounce stage and the I2C byte master in the top level.

---
 rtl/key_i2c_cmd.sv | 191 +++++++++++++++++++
 tb/tb_key_i2c_cmd.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_i2c_cmd.sv
// key_i2c_cmd: turns single-cycle write/read key presses into I2C master
// transaction requests, waits for completion with a timeout, keeps the last
// read byte and a sticky timeout flag.
// Optional feature macro: KEY_I2C_AUTO_INC_EN (word address advances after
// every successful transaction; otherwise the address is fixed at BASE_ADDR).
module key_i2c_cmd #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter logic [7:0]        WDATA_INIT  = 8'h01,
  parameter int unsigned       TIMEOUT_CYC = 500000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_press,
  input  logic              rd_press,
  input  logic              i2c_done,
  input  logic [7:0]        i2c_rdata,
  output logic              i2c_start,
  output logic              i2c_rw,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_wdata,
  output logic              busy,
  output logic [7:0]        rd_byte,
  output logic              err
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_vld;
  logic             r_pend_rw;
  logic             r_start;
  logic             r_rw;
  logic [7:0]       r_wdata;
  logic             r_busy;
  logic [7:0]       r_rd_byte;
  logic             r_err;

  logic w_any_press;
  logic w_go;
  logic w_sel_rw;
  logic w_cnt_last;
  logic w_start_nxt;
  logic w_load_rw;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_capture;
  logic w_timeout;
  logic w_finish;
  logic w_pend_clr;
  logic w_pend_set;

  // A queued request is served before a fresh press; write beats read.
  assign w_any_press = wr_press | rd_press;
  assign w_go        = r_pend_vld | w_any_press;
  assign w_sel_rw    = r_pend_vld ? r_pend_rw : ~wr_press;
  assign w_cnt_last  = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: done has priority over the terminal timeout count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_ISSUE;
        else      w_state_nxt = S_IDLE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i2c_done)        w_state_nxt = S_DONE;
        else if (w_cnt_last) w_state_nxt = S_IDLE;
        else                 w_state_nxt = S_WAIT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath registers
  always_comb begin
    w_start_nxt = 1'b0;
    w_load_rw   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_start_nxt = 1'b1;
          w_load_rw   = 1'b1;
          w_pend_clr  = 1'b1;
        end else begin
          w_start_nxt = 1'b0;
        end
      end
      S_ISSUE: w_cnt_clr = 1'b1;
      S_WAIT: begin
        w_cnt_inc = 1'b1;
        if (i2c_done)        w_capture = r_rw;
        else if (w_cnt_last) w_timeout = 1'b1;
        else                 w_timeout = 1'b0;
      end
      S_DONE:  w_finish = 1'b1;
      default: w_finish = 1'b0;
    endcase
    w_pend_set = (r_state != S_IDLE) && !r_pend_vld && w_any_press;
  end

  // Request outputs, busy flag and timeout counter
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_start <= 1'b0;
      r_rw    <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_start <= w_start_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_load_rw) r_rw <= w_sel_rw;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // One-deep pending request slot; first press while busy wins
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pend_vld <= 1'b0;
      r_pend_rw  <= 1'b0;
    end else if (w_pend_clr) begin
      r_pend_vld <= 1'b0;
    end else if (w_pend_set) begin
      r_pend_vld <= 1'b1;
      r_pend_rw  <= ~wr_press;
    end
  end

  // Write data advance, read capture and sticky error flag
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_wdata   <= WDATA_INIT;
      r_rd_byte <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      if (w_finish && !r_rw) r_wdata <= r_wdata + 8'd1;
      if (w_capture) r_rd_byte <= i2c_rdata;
      if (w_timeout)     r_err <= 1'b1;
      else if (w_finish) r_err <= 1'b0;
    end
  end

`ifdef KEY_I2C_AUTO_INC_EN
  logic [ADDR_W-1:0] r_addr;

  // Word address advances after each successful transaction, never on timeout
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)      r_addr <= BASE_ADDR;
    else if (w_finish) r_addr <= r_addr + ADDR_W'(1);
  end

  assign i2c_addr = r_addr;
`else
  assign i2c_addr = BASE_ADDR;
`endif

  assign i2c_start = r_start;
  assign i2c_rw    = r_rw;
  assign i2c_wdata = r_wdata;
  assign busy      = r_busy;
  assign rd_byte   = r_rd_byte;
  assign err       = r_err;

endmodule

// File: tb/tb_key_i2c_cmd.sv
// tb_key_i2c_cmd: directed stimulus for key_i2c_cmd with a transaction-level
// reference model checked every cycle, plus hand-computed literal checkpoints.
// A second instance (4-bit address, base 4'hE) runs the same stimulus to
// exercise address wrap when KEY_I2C_AUTO_INC_EN is defined.
module tb_key_i2c_cmd;
  localparam int TO = 8;
`ifdef KEY_I2C_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wr_press, rd_press, i2c_done;
  logic [7:0]  i2c_rdata;
  logic        i2c_start, i2c_rw, busy, err;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wdata, rd_byte;
  logic        s4, rw4, busy4, err4;
  logic [3:0]  addr4;
  logic [7:0]  wdata4, rd4;

  always #5 sys_clk = ~sys_clk;

  key_i2c_cmd #(.ADDR_W(16), .BASE_ADDR(16'h0000), .WDATA_INIT(8'h01), .TIMEOUT_CYC(TO)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_press(wr_press), .rd_press(rd_press),
    .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .i2c_start(i2c_start), .i2c_rw(i2c_rw),
    .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .busy(busy), .rd_byte(rd_byte), .err(err));

  key_i2c_cmd #(.ADDR_W(4), .BASE_ADDR(4'hE), .WDATA_INIT(8'h01), .TIMEOUT_CYC(TO)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_press(wr_press), .rd_press(rd_press),
    .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .i2c_start(s4), .i2c_rw(rw4),
    .i2c_addr(addr4), .i2c_wdata(wdata4), .busy(busy4), .rd_byte(rd4), .err(err4));

  int errors = 0;
  int checks = 0;
  int n_starts = 0;

  // Reference model: one transaction in flight, a queue of at most one request.
  bit          m_busy;
  int          m_since;   // 0 = request cycle, 1.. = cycles spent waiting
  bit          m_fin;     // completion cycle pending
  bit          pend_q[$];
  logic        e_start, e_rw, e_busy, e_err;
  logic [7:0]  e_wdata, e_rd;
  logic [15:0] e_addr;
  logic [3:0]  e_addr4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_since = 0; m_fin = 1'b0; pend_q.delete();
    e_start = 1'b0; e_rw = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_wdata = 8'h01; e_rd = 8'h00; e_addr = 16'h0000; e_addr4 = 4'hE;
  endtask

  task automatic model_step();
    bit go;
    bit sel;
    bit n_start;
    go = 1'b0; sel = 1'b0; n_start = 1'b0;
    if (!m_busy) begin
      if (pend_q.size() > 0) begin sel = pend_q.pop_front(); go = 1'b1; end
      else if (wr_press)     begin sel = 1'b0; go = 1'b1; end
      else if (rd_press)     begin sel = 1'b1; go = 1'b1; end
      if (go) begin
        e_rw = sel; n_start = 1'b1; m_busy = 1'b1; m_since = 0; m_fin = 1'b0;
      end
    end else begin
      if (pend_q.size() == 0 && (wr_press || rd_press)) pend_q.push_back(wr_press ? 1'b0 : 1'b1);
      if (m_fin) begin
        m_busy = 1'b0; e_err = 1'b0;
        if (!e_rw) e_wdata = e_wdata + 8'd1;
        if (AUTO) begin e_addr = e_addr + 16'd1; e_addr4 = e_addr4 + 4'd1; end
      end else if (m_since == 0) begin
        m_since = 1;
      end else if (i2c_done) begin
        m_fin = 1'b1;
        if (e_rw) e_rd = i2c_rdata;
      end else if (m_since == TO) begin
        m_busy = 1'b0; e_err = 1'b1;
      end else begin
        m_since++;
      end
    end
    e_start = n_start;
    e_busy  = m_busy;
  endtask

  task automatic compare();
    chk("start", i2c_start, e_start);
    chk("rw", i2c_rw, e_rw);
    chk("addr", i2c_addr, e_addr);
    chk("wdata", i2c_wdata, e_wdata);
    chk("busy", busy, e_busy);
    chk("rd_byte", rd_byte, e_rd);
    chk("err", err, e_err);
    chk("addr4", addr4, e_addr4);
    chk("start4", s4, e_start);
    if (i2c_start) n_starts++;
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare at negedge.
  task automatic cyc(input logic wr, input logic rd, input logic dn, input logic [7:0] rdat);
    wr_press = wr; rd_press = rd; i2c_done = dn; i2c_rdata = rdat;
    @(posedge sys_clk);
    if (!sys_rst) model_reset();
    else          model_step();
    @(negedge sys_clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  int s0;

  initial begin
    sys_rst = 1'b0; wr_press = 1'b0; rd_press = 1'b0; i2c_done = 1'b0; i2c_rdata = 8'h00;
    model_reset();
    @(negedge sys_clk);
    idle(3);
    chk("rst_start", i2c_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wdata", i2c_wdata, 8'h01);
    chk("rst_rd", rd_byte, 8'h00);
    chk("rst_addr4", addr4, 4'hE);
    sys_rst = 1'b1;
    idle(2);

    // Write: start one cycle after press, wdata advances two cycles after done
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("w1_start", i2c_start, 1'b1);
    chk("w1_rw", i2c_rw, 1'b0);
    chk("w1_addr", i2c_addr, 16'h0000);
    chk("w1_wdata", i2c_wdata, 8'h01);
    chk("w1_busy", busy, 1'b1);
    idle(4);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    idle(1);
    chk("w1_wdata_inc", i2c_wdata, 8'h02);
    chk("w1_busy_end", busy, 1'b0);
`ifdef KEY_I2C_AUTO_INC_EN
    chk("w1_addr_inc", i2c_addr, 16'h0001);
    chk("w1_addr4_inc", addr4, 4'hF);
`endif

    // Read returning A5
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("r1_rw", i2c_rw, 1'b1);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5);
    chk("r1_rd", rd_byte, 8'hA5);
    idle(1);
    chk("r1_err", err, 1'b0);
`ifdef KEY_I2C_AUTO_INC_EN
    chk("r1_addr4_wrap", addr4, 4'h0);
`else
    chk("r1_addr_fixed", i2c_addr, 16'h0000);
`endif

    // Simultaneous presses: one write only
    s0 = n_starts;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("sim_rw", i2c_rw, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    idle(4);
    chk("sim_one_start", n_starts - s0, 1);

    // Queued read behind a write, second read press dropped
    s0 = n_starts;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    idle(1);
    chk("q_idle_nostart", i2c_start, 1'b0);
    idle(1);
    chk("q_start", i2c_start, 1'b1);
    chk("q_rw", i2c_rw, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 8'h3C);
    idle(4);
    chk("q_starts", n_starts - s0, 2);
    chk("q_rd", rd_byte, 8'h3C);

    // Timeout on a write: err exactly after TO waiting cycles, data unchanged
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(8);
    chk("to_err_before", err, 1'b0);
    chk("to_busy_before", busy, 1'b1);
    idle(1);
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_wdata", i2c_wdata, 8'h04);

    // Successful read clears err
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 8'h77);
    idle(1);
    chk("clr_err", err, 1'b0);
    chk("clr_rd", rd_byte, 8'h77);

    // Done coincident with terminal count: done wins
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(8);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("tc_err", err, 1'b0);
    chk("tc_busy", busy, 1'b1);
    idle(1);
    chk("tc_wdata", i2c_wdata, 8'h05);

    // Done in IDLE and in ISSUE is ignored
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("dn_idle_busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);
    chk("dn_issue_busy", busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);
    chk("dn_issue_wdata", i2c_wdata, 8'h06);

    // Reset mid-transaction with a queued press: nothing restarts
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    sys_rst = 1'b0;
    idle(2);
    sys_rst = 1'b1;
    s0 = n_starts;
    idle(6);
    chk("mr_starts", n_starts - s0, 0);
    chk("mr_wdata", i2c_wdata, 8'h01);
    chk("mr_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
